// File: rtl/seg7_scan_driver.sv
// Scans a 16-bit hex value across a multiplexed 4-digit 7-segment display, one digit per slot,
// with a dark guard at each slot start; pins are registered (1-cycle latency), loads are committed at frame end.
module seg7_scan_driver #(
    parameter int DIG_TICKS   = 50000,
    parameter int BLANK_TICKS = 500
) (
    input  logic        FPGA_CLK,
    input  logic        RESET,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        load,
    input  logic        lz_blank,
    input  logic        enable,
    output logic [3:0]  DIG,
    output logic [7:0]  SEG,
    output logic        frame_tick
);

    localparam int CW = (DIG_TICKS > 2) ? $clog2(DIG_TICKS) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(DIG_TICKS - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(BLANK_TICKS);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_pend_val;
    logic [3:0]    r_pend_dp;
    logic [15:0]   r_act_val;
    logic [3:0]    r_act_dp;

    logic          w_last_slot;
    logic          w_frame_end;
    logic [3:0]    w_nib;
    logic          w_lead_zero;
    logic [3:0]    w_dig_nxt;
    logic [7:0]    w_seg_nxt;

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0: hex_font = 7'b1000000;
            4'h1: hex_font = 7'b1111001;
            4'h2: hex_font = 7'b0100100;
            4'h3: hex_font = 7'b0110000;
            4'h4: hex_font = 7'b0011001;
            4'h5: hex_font = 7'b0010010;
            4'h6: hex_font = 7'b0000010;
            4'h7: hex_font = 7'b1111000;
            4'h8: hex_font = 7'b0000000;
            4'h9: hex_font = 7'b0010000;
            4'hA: hex_font = 7'b0001000;
            4'hB: hex_font = 7'b0000011;
            4'hC: hex_font = 7'b1000110;
            4'hD: hex_font = 7'b0100001;
            4'hE: hex_font = 7'b0000110;
            default: hex_font = 7'b0001110;
        endcase
    endfunction

    assign w_last_slot = (r_cnt == LAST_CNT);
    assign w_frame_end = w_last_slot && (r_idx == 2'd3);

    // Digit 0 is the leftmost, i.e. the most significant nibble.
    always_comb begin
        w_nib       = r_act_val[3:0];
        w_lead_zero = 1'b0;
        case (r_idx)
            2'd0: begin
                w_nib       = r_act_val[15:12];
                w_lead_zero = (r_act_val[15:12] == 4'h0);
            end
            2'd1: begin
                w_nib       = r_act_val[11:8];
                w_lead_zero = (r_act_val[15:8] == 8'h00);
            end
            2'd2: begin
                w_nib       = r_act_val[7:4];
                w_lead_zero = (r_act_val[15:4] == 12'h000);
            end
            default: begin
                w_nib       = r_act_val[3:0];
                w_lead_zero = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_dig_nxt = 4'b1111;
        w_seg_nxt = 8'hFF;
        if (enable && (r_cnt >= GUARD_END)) begin
            w_dig_nxt      = ~(4'b0001 << r_idx);
            w_seg_nxt[7]   = ~r_act_dp[r_idx];
            w_seg_nxt[6:0] = (lz_blank && w_lead_zero) ? 7'h7F : hex_font(w_nib);
        end
    end

    always_ff @(posedge FPGA_CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt      <= '0;
            r_idx      <= 2'd0;
            r_pend_val <= 16'h0000;
            r_pend_dp  <= 4'h0;
            r_act_val  <= 16'h0000;
            r_act_dp   <= 4'h0;
            DIG        <= 4'b1111;
            SEG        <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            r_cnt      <= w_last_slot ? '0 : r_cnt + 1'b1;
            if (w_last_slot) begin
                r_idx <= r_idx + 2'd1;
            end
            if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp;
            end
            // A load landing on the boundary bypasses pending so it is not lost for a frame.
            if (w_frame_end) begin
                r_act_val <= load ? value : r_pend_val;
                r_act_dp  <= load ? dp    : r_pend_dp;
            end
            DIG        <= w_dig_nxt;
            SEG        <= w_seg_nxt;
            frame_tick <= w_frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random stimulus, compared every cycle
// against a model that derives slot position from elapsed cycles since reset.
module tb_seg7_scan_driver;

    localparam int DT = 8;
    localparam int BT = 2;

    logic        clk = 1'b0;
    logic        RESET;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        lz_blank;
    logic        enable;
    logic [3:0]  DIG;
    logic [7:0]  SEG;
    logic        frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          t;
    logic [15:0] m_pend_v, m_act_v;
    logic [3:0]  m_pend_dp, m_act_dp;
    logic [3:0]  e_dig;
    logic [7:0]  e_seg;
    logic        e_ft;

    logic [6:0] font_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_driver #(.DIG_TICKS(DT), .BLANK_TICKS(BT)) dut (
        .FPGA_CLK   (clk),
        .RESET      (RESET),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .lz_blank   (lz_blank),
        .enable     (enable),
        .DIG        (DIG),
        .SEG        (SEG),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t         = 0;
        m_pend_v  = 16'h0;
        m_pend_dp = 4'h0;
        m_act_v   = 16'h0;
        m_act_dp  = 4'h0;
        e_dig     = 4'hF;
        e_seg     = 8'hFF;
        e_ft      = 1'b0;
    endtask

    task automatic tick();
        int cnt, idx;
        logic [15:0] upper;
        logic        blank;
        @(posedge clk);
        if (RESET) begin
            model_reset();
        end else begin
            cnt   = t % DT;
            idx   = (t / DT) % 4;
            e_dig = 4'hF;
            e_seg = 8'hFF;
            if (enable && cnt >= BT) begin
                upper = m_act_v >> (4 * (3 - idx));
                blank = lz_blank && idx < 3 && upper == 16'h0;
                e_dig = 4'hF & ~(4'b0001 << idx);
                e_seg = {~m_act_dp[idx], blank ? 7'h7F : font_tbl[upper[3:0]]};
            end
            e_ft = (cnt == DT - 1) && (idx == 3);
            if (e_ft) begin
                m_act_v  = load ? value : m_pend_v;
                m_act_dp = load ? dp    : m_pend_dp;
            end
            if (load) begin
                m_pend_v  = value;
                m_pend_dp = dp;
            end
            t++;
        end
        #1;
        check("DIG", 32'(DIG), 32'(e_dig));
        check("SEG", 32'(SEG), 32'(e_seg));
        check("frame_tick", 32'(frame_tick), 32'(e_ft));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    // Advance until the next edge is the one sampling the frame-boundary state.
    task automatic seek_boundary();
        int guard = 0;
        while (!((t % DT == DT - 1) && ((t / DT) % 4 == 3)) && guard < 4 * DT + 2) begin
            tick();
            guard++;
        end
        check("seek_boundary_timeout", 32'(guard <= 4 * DT), 32'd1);
    endtask

    initial begin
        RESET    = 1'b1;
        value    = 16'h0;
        dp       = 4'h0;
        load     = 1'b0;
        lz_blank = 1'b0;
        enable   = 1'b1;
        model_reset();

        repeat (3) tick();
        check("rst_DIG", 32'(DIG), 32'h0000000F);
        check("rst_SEG", 32'(SEG), 32'h000000FF);
        check("rst_frame_tick", 32'(frame_tick), 32'h0);
        @(negedge clk);
        RESET = 1'b0;

        // Reset value scanned with no load
        repeat (70) tick();

        // Mid-frame load must not appear until the frame boundary
        repeat (9) tick();
        do_load(16'h1A8F, 4'b0100);
        repeat (80) tick();

        // Leading-zero blanking
        lz_blank = 1'b1;
        do_load(16'h0005, 4'b0000);
        repeat (70) tick();
        do_load(16'h0000, 4'b0010);
        repeat (70) tick();
        lz_blank = 1'b0;

        // Load coinciding with the boundary, then two loads in one frame
        seek_boundary();
        do_load(16'h4C2E, 4'b1001);
        repeat (40) tick();
        repeat (5) tick();
        do_load(16'h1111, 4'b0001);
        repeat (3) tick();
        do_load(16'h2222, 4'b1000);
        repeat (70) tick();

        // Display disabled mid-frame
        repeat (5) tick();
        enable = 1'b0;
        repeat (10) tick();
        enable = 1'b1;
        repeat (70) tick();

        // Asynchronous reset during the drive phase of digit 2
        begin
            int guard = 0;
            while (!(((t / DT) % 4 == 2) && (t % DT >= BT + 2)) && guard < 4 * DT + 2) begin
                tick();
                guard++;
            end
            check("seek_dig2_timeout", 32'(guard <= 4 * DT), 32'd1);
        end
        check("pre_rst_DIG", 32'(DIG), 32'h0000000B);
        #2;
        RESET = 1'b1;
        model_reset();
        #1;
        check("async_rst_DIG", 32'(DIG), 32'h0000000F);
        check("async_rst_SEG", 32'(SEG), 32'h000000FF);
        repeat (2) tick();
        @(negedge clk);
        RESET = 1'b0;
        tick();
        tick();
        tick();
        check("first_drive_DIG", 32'(DIG), 32'h0000000E);
        check("first_drive_SEG", 32'(SEG), 32'h000000C0);
        repeat (40) tick();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            load   = ($urandom % 12) == 0;
            value  = 16'($urandom);
            if (($urandom % 3) == 0) value = value & 16'h00FF;
            dp     = 4'($urandom);
            if (($urandom % 50) == 0) lz_blank = ~lz_blank;
            enable = ($urandom % 20) != 0;
            tick();
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
